axi4_slave_mem_arbiter: RTL

Shares the AXI4 slave's single-port backing memory between the read-data engine and the write-data engine. Each engine requests ownership for a whole burst. The arbiter grants one engine at a time using round-robin, holds the grant until the owner signals burst completion, and muxes the owner's memory strobes onto the memory port. It sits between the two channel engines and the memory model inside the slave top.

---
 rtl/axi4_slave_mem_arbiter_if.sv | 46 ++++
 rtl/axi4_slave_mem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/axi4_slave_mem_arbiter_if.sv
// Bus bundle between the read/write channel engines, the memory port and the arbiter.
// The arbiter uses the slave modport; engines and memory model sit on the master side.
interface axi4_slave_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  rd_req;
    logic                  rd_done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic                  wr_done;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_gnt;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_strb;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [15:0]           stall_cnt;

    modport slave (
        input  rd_req, rd_done, rd_en, rd_addr,
        input  wr_req, wr_done, wr_en, wr_addr, wr_data, wr_strb,
        input  mem_rdata,
        output rd_gnt, rd_data, wr_gnt,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_strb,
        output stall_cnt
    );

    modport master (
        output rd_req, rd_done, rd_en, rd_addr,
        output wr_req, wr_done, wr_en, wr_addr, wr_data, wr_strb,
        output mem_rdata,
        input  rd_gnt, rd_data, wr_gnt,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_strb,
        input  stall_cnt
    );
endinterface

// File: rtl/axi4_slave_mem_arbiter.sv
// Round-robin burst arbiter sharing the single-port backing memory between read and write engines.
// Optional macro AXI_MEM_ARB_RDATA_REG_EN registers rd_data (read latency 1 -> 2 cycles).
//
// state  | meaning
// IDLE   | no owner, memory port quiet
// RD_OWN | read engine owns memory until rd_done
// WR_OWN | write engine owns memory until wr_done
module axi4_slave_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input logic                    clk,
    input logic                    rst,
    axi4_slave_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_OWN = 2'd1,
        WR_OWN = 2'd2
    } state_t;

    state_t                state;
    logic                  rd_gnt;
    logic                  wr_gnt;
    logic                  last_wr;
    logic [15:0]           stall_cnt;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_strb;

    // last_wr resets to 0 (read served last) so the write engine wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rd_gnt  <= 1'b0;
            wr_gnt  <= 1'b0;
            last_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_req && (!bus.rd_req || !last_wr)) begin
                        state   <= WR_OWN;
                        wr_gnt  <= 1'b1;
                        last_wr <= 1'b1;
                    end else if (bus.rd_req) begin
                        state   <= RD_OWN;
                        rd_gnt  <= 1'b1;
                        last_wr <= 1'b0;
                    end
                end
                RD_OWN: begin
                    if (bus.rd_done) begin
                        rd_gnt <= 1'b0;
                        if (bus.wr_req) begin
                            state   <= WR_OWN;
                            wr_gnt  <= 1'b1;
                            last_wr <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WR_OWN: begin
                    if (bus.wr_done) begin
                        wr_gnt <= 1'b0;
                        if (bus.rd_req) begin
                            state   <= RD_OWN;
                            rd_gnt  <= 1'b1;
                            last_wr <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    rd_gnt <= 1'b0;
                    wr_gnt <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if (((bus.rd_req && wr_gnt) || (bus.wr_req && rd_gnt)) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Decoded from state so an async reset silences the port immediately.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_strb  = '0;
        case (state)
            RD_OWN: begin
                mem_en   = bus.rd_en;
                mem_addr = bus.rd_addr;
            end
            WR_OWN: begin
                mem_en    = bus.wr_en;
                mem_we    = 1'b1;
                mem_addr  = bus.wr_addr;
                mem_wdata = bus.wr_data;
                mem_strb  = bus.wr_strb;
            end
            default: ;
        endcase
    end

`ifdef AXI_MEM_ARB_RDATA_REG_EN
    logic [DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= bus.mem_rdata;
        end
    end

    assign bus.rd_data = rd_data;
`else
    assign bus.rd_data = bus.mem_rdata;
`endif

    assign bus.rd_gnt    = rd_gnt;
    assign bus.wr_gnt    = wr_gnt;
    assign bus.stall_cnt = stall_cnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_strb  = mem_strb;
endmodule
